uart_frame_parser: RTL

Byte-stream framer that sits directly downstream of the UART receiver. It consumes received bytes, recognises frames of the form SYNC, LEN, PAYLOAD[LEN], CHK, and buffers the payload. It releases only checksum-verified payloads to the downstream consumer over a valid/ready stream. Corrupt, truncated or oversized frames are discarded and reported.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_frame_buf.sv | 23 ++
 rtl/uart_frame_parser.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: state encoding, error codes, default sync marker.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_LEN = 3'd1,
    GET_PAY = 3'd2,
    GET_CHK = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: MAX_LEN x 8 register file, one synchronous write port, combinational read.
// Storage is not reset; the parser only reads locations written by the current frame.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frames SYNC/LEN/PAYLOAD/CHK from a UART byte stream; payload drains 1 cycle after CHK, held under !out_ready,
// and strobes arriving during DRAIN are dropped as overruns. UART_FRAME_TIMEOUT_EN adds an inter-byte gap timeout.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 8680
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int PTR_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] len_q, len_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       chk_q, chk_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic             drain_last;
  logic             receiving;
  logic             timeout_hit;

  assign receiving  = (state_q == GET_LEN) || (state_q == GET_PAY) || (state_q == GET_CHK);
  assign drain_last = (rd_ptr_q == (len_q - PTR_ONE));

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_ptr_q[BUF_AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q[BUF_AW-1:0]),
    .rd_data (buf_rdata)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int               GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

  logic [GAP_W-1:0] gap_q, gap_d;

  // Counter clears on any strobe and whenever no frame is being received.
  always_comb begin
    gap_d       = '0;
    timeout_hit = 1'b0;
    if (receiving && !in_valid) begin
      if (gap_q == GAP_LIMIT) timeout_hit = 1'b1;
      else                    gap_d       = gap_q + GAP_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gap_q <= '0;
    else      gap_q <= gap_d;
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    chk_d       = chk_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    if (timeout_hit) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      err_code_d  = ERR_OVR;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && (in_data == SYNC_BYTE)) state_d = GET_LEN;
        end
        GET_LEN: begin
          if (in_valid) begin
            if ((in_data == 8'd0) || (int'(in_data) > MAX_LEN)) begin
              state_d     = IDLE;
              frame_err_d = 1'b1;
              err_code_d  = ERR_LEN;
            end else begin
              len_d    = in_data[PTR_W-1:0];
              wr_ptr_d = '0;
              chk_d    = in_data;
              state_d  = GET_PAY;
            end
          end
        end
        GET_PAY: begin
          if (in_valid) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            chk_d    = chk_q ^ in_data;
            if (wr_ptr_q == (len_q - PTR_ONE)) state_d = GET_CHK;
          end
        end
        GET_CHK: begin
          if (in_valid) begin
            if (in_data == chk_q) begin
              frame_ok_d = 1'b1;
              rd_ptr_d   = '0;
              state_d    = DRAIN;
            end else begin
              state_d     = IDLE;
              frame_err_d = 1'b1;
              err_code_d  = ERR_CHK;
            end
          end
        end
        DRAIN: begin
          // The buffer is busy, so any new byte is lost; the drain itself continues.
          if (in_valid) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVR;
          end
          if (out_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (drain_last) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      chk_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      chk_q       <= chk_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? buf_rdata : 8'd0;
  assign out_last  = out_valid && drain_last;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule
